psum_collector: RTL and testbench

//  Sits directly downstream of the PE POUT port and consumes its PEROW-wide psum vectors.

---
 rtl/psum_collector.sv | 92 +++++++++
 tb/tb_psum_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// psum_collector: accumulates PE psum vectors into a saturating bank and drains it OUTN lanes per beat.
// Optional feature macro PSUM_RELU_EN: negative lanes are output as 0 during drain (bank unchanged).
module psum_collector #(
   parameter int PEROW = 16,
   parameter int PSUMDWD = 16,
   parameter int OUTN = 4,
   localparam int NBEAT = PEROW / OUTN,
   localparam int BW = NBEAT > 1 ? $clog2(NBEAT) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       Psum_rdy,
   output logic                       Psum_ack,
   input  logic [PEROW*PSUMDWD-1:0]   i_Psum,
   input  logic                       i_first,
   input  logic                       i_last,
   output logic                       Out_rdy,
   input  logic                       Out_ack,
   output logic [OUTN*PSUMDWD-1:0]    o_Out,
   output logic [BW-1:0]              o_beat,
   output logic                       o_ovf
);
   localparam int IW = PEROW > 1 ? $clog2(PEROW) : 1;
   typedef enum logic {ACC, DRAIN} state_t;
   state_t state, state_nx;
   logic [PSUMDWD-1:0] bank [PEROW];
   logic [PSUMDWD-1:0] acc [PEROW];
   logic [PSUMDWD:0] sum [PEROW];
   logic [PEROW-1:0] sat;
   logic [PSUMDWD-1:0] lane;
   logic [BW-1:0] beat;
   logic ovf;
   logic psum_xfer, out_xfer, last_beat;

   assign Psum_ack = state == ACC;
   assign Out_rdy = state == DRAIN;
   assign psum_xfer = Psum_rdy && Psum_ack;
   assign out_xfer = Out_rdy && Out_ack;
   assign last_beat = beat == BW'(NBEAT - 1);
   assign o_beat = beat;
   assign o_ovf = ovf;

   // next state: drain after a last vector, back to accumulate after the final beat
   always_comb begin
      state_nx = state;
      if (psum_xfer && i_last) state_nx = DRAIN;
      else if (out_xfer && last_beat) state_nx = ACC;
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) state <= ACC;
      else state <= state_nx;

   // per-lane sign-extended add, clamped to the signed range on overflow
   always_comb begin
      for (int i = 0; i < PEROW; i++) begin
         sum[i] = {bank[i][PSUMDWD-1], bank[i]} + {i_Psum[i*PSUMDWD+PSUMDWD-1], i_Psum[i*PSUMDWD +: PSUMDWD]};
         sat[i] = sum[i][PSUMDWD] ^ sum[i][PSUMDWD-1];
         acc[i] = sat[i] ? {sum[i][PSUMDWD], {(PSUMDWD-1){~sum[i][PSUMDWD]}}} : sum[i][PSUMDWD-1:0];
      end
   end

   // bank, beat counter and sticky overflow; bank clears itself after the final beat
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         for (int i = 0; i < PEROW; i++) bank[i] <= '0;
         beat <= '0;
         ovf <= 1'b0;
      end else if (psum_xfer) begin
         for (int i = 0; i < PEROW; i++) bank[i] <= i_first ? i_Psum[i*PSUMDWD +: PSUMDWD] : acc[i];
         ovf <= !i_first && (ovf || |sat);
      end else if (out_xfer) begin
         if (last_beat) begin
            for (int i = 0; i < PEROW; i++) bank[i] <= '0;
            beat <= '0;
         end else beat <= beat + 1'b1;
      end

   // output beat selection, zero outside drain
   always_comb begin
      o_Out = '0;
      lane = '0;
      for (int j = 0; j < OUTN; j++) begin
         lane = bank[IW'(int'(beat) * OUTN + j)];
`ifdef PSUM_RELU_EN
         if (lane[PSUMDWD-1]) lane = '0;
`endif
         o_Out[j*PSUMDWD +: PSUMDWD] = Out_rdy ? lane : '0;
      end
   end
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed bench for psum_collector (default parameters).
module tb_psum_collector;
   localparam int PEROW = 16;
   localparam int W = 16;
   localparam int OUTN = 4;
   localparam int NBEAT = 4;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   logic Psum_rdy = 1'b0;
   logic Psum_ack;
   logic [PEROW*W-1:0] i_Psum = '0;
   logic i_first = 1'b0;
   logic i_last = 1'b0;
   logic Out_rdy;
   logic Out_ack = 1'b0;
   logic [OUTN*W-1:0] o_Out;
   logic [1:0] o_beat;
   logic o_ovf;

   int checks = 0;
   int errors = 0;

   psum_collector dut (
      .i_clk(i_clk), .i_rst(i_rst), .Psum_rdy(Psum_rdy), .Psum_ack(Psum_ack),
      .i_Psum(i_Psum), .i_first(i_first), .i_last(i_last), .Out_rdy(Out_rdy),
      .Out_ack(Out_ack), .o_Out(o_Out), .o_beat(o_beat), .o_ovf(o_ovf)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [PEROW*W-1:0] fill(input logic [W-1:0] x);
      return {PEROW{x}};
   endfunction

   task automatic send(input logic f, input logic l, input logic [PEROW*W-1:0] v);
      int n = 0;
      Psum_rdy = 1'b1; i_first = f; i_last = l; i_Psum = v;
      while (!Psum_ack && n < 20) begin tick; n++; end
      checks++;
      if (!Psum_ack) begin errors++; $display("FAIL send_timeout Psum_ack=%b required 1", Psum_ack); end
      tick;
      Psum_rdy = 1'b0; i_first = 1'b0; i_last = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) tick;
      checks++;
      if ({Psum_ack, Out_rdy, o_beat, o_ovf} !== 5'b10000) begin
         errors++; $display("FAIL reset_ctrl ack/rdy/beat/ovf=%b required 10000", {Psum_ack, Out_rdy, o_beat, o_ovf});
      end
      checks++;
      if (o_Out !== '0) begin errors++; $display("FAIL reset_out o_Out=%h required 0", o_Out); end
      i_rst = 1'b1;
      tick;
   endtask

   task automatic test_reset_mid_drain;
      logic [OUTN*W-1:0] exp;
      send(1'b1, 1'b1, fill(16'd9));
      Out_ack = 1'b1;
      tick; tick;
      checks++;
      if (o_beat !== 2'd2) begin errors++; $display("FAIL rmd_pre_beat o_beat=%0d required 2", o_beat); end
      Out_ack = 1'b0;
      #2 i_rst = 1'b0;
      #1;
      checks++;
      if ({Out_rdy, o_beat, Psum_ack} !== 4'b0001 || o_Out !== '0) begin
         errors++; $display("FAIL rmd_async rdy/beat/ack=%b o_Out=%h required 0001 and 0", {Out_rdy, o_beat, Psum_ack}, o_Out);
      end
      tick;
      i_rst = 1'b1;
      tick;
      send(1'b0, 1'b1, fill(16'd3));
      Out_ack = 1'b1;
      exp = {OUTN{16'd3}};
      for (int b = 0; b < NBEAT; b++) begin
         checks++;
         if (!Out_rdy || o_beat !== 2'(b) || o_Out !== exp) begin
            errors++; $display("FAIL rmd_drain beat=%0d rdy=%b o_Out=%h required beat %0d %h", o_beat, Out_rdy, o_Out, b, exp);
         end
         tick;
      end
      Out_ack = 1'b0;
   endtask

   task automatic test_three_pass;
      logic [OUTN*W-1:0] exp;
      exp = {OUTN{16'd15}};
      Out_ack = 1'b1;
      send(1'b1, 1'b0, fill(16'd5));
      send(1'b0, 1'b0, fill(16'd5));
      send(1'b0, 1'b1, fill(16'd5));
      for (int b = 0; b < NBEAT; b++) begin
         checks++;
         if (!Out_rdy || Psum_ack || o_beat !== 2'(b) || o_Out !== exp || o_ovf) begin
            errors++; $display("FAIL three_pass rdy=%b ack=%b beat=%0d o_Out=%h ovf=%b required 1 0 %0d %h 0", Out_rdy, Psum_ack, o_beat, o_Out, o_ovf, b, exp);
         end
         tick;
      end
      checks++;
      if (!Psum_ack || Out_rdy) begin errors++; $display("FAIL three_pass_return ack=%b rdy=%b required 1 0", Psum_ack, Out_rdy); end
      Out_ack = 1'b0;
   endtask

   task automatic test_saturation;
      logic [PEROW*W-1:0] v;
      logic [OUTN*W-1:0] exp;
      v = '0; v[15:0] = 16'd30000; v[31:16] = 16'hFFFF - 16'd29999;
      Out_ack = 1'b1;
      send(1'b1, 1'b0, v);
      v[15:0] = 16'd10000; v[31:16] = 16'hFFFF - 16'd9999;
      send(1'b0, 1'b1, v);
      for (int b = 0; b < NBEAT; b++) begin
         exp = (b == 0) ? {16'h0, 16'h0, 16'h8000, 16'h7FFF} : '0;
         checks++;
         if (!Out_rdy || o_beat !== 2'(b) || o_Out !== exp || !o_ovf) begin
            errors++; $display("FAIL saturation beat=%0d o_Out=%h ovf=%b required beat %0d %h ovf 1", o_beat, o_Out, o_ovf, b, exp);
         end
         tick;
      end
      checks++;
      if (!o_ovf) begin errors++; $display("FAIL ovf_sticky o_ovf=%b required 1", o_ovf); end
      Out_ack = 1'b0;
   endtask

   task automatic test_relu;
      logic [PEROW*W-1:0] v;
      logic [OUTN*W-1:0] exp;
      v = '0; v[63:48] = 16'hFFF8;
      Out_ack = 1'b1;
      send(1'b1, 1'b1, v);
      for (int b = 0; b < NBEAT; b++) begin
`ifdef PSUM_RELU_EN
         exp = '0;
`else
         exp = (b == 0) ? {16'hFFF8, 48'h0} : '0;
`endif
         checks++;
         if (!Out_rdy || o_beat !== 2'(b) || o_Out !== exp || o_ovf) begin
            errors++; $display("FAIL relu beat=%0d o_Out=%h ovf=%b required beat %0d %h ovf 0", o_beat, o_Out, o_ovf, b, exp);
         end
         tick;
      end
      Out_ack = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [PEROW*W-1:0] v;
      logic [OUTN*W-1:0] exp;
      for (int i = 0; i < PEROW; i++) v[i*W +: W] = 16'(i);
      send(1'b1, 1'b1, v);
      Out_ack = 1'b1;
      for (int j = 0; j < OUTN; j++) exp[j*W +: W] = 16'(j);
      checks++;
      if (o_beat !== 2'd0 || o_Out !== exp) begin errors++; $display("FAIL bp_beat0 beat=%0d o_Out=%h required 0 %h", o_beat, o_Out, exp); end
      tick;
      Out_ack = 1'b0;
      Psum_rdy = 1'b1; i_Psum = fill(16'd100);
      for (int j = 0; j < OUTN; j++) exp[j*W +: W] = 16'(4 + j);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (!Out_rdy || Psum_ack || o_beat !== 2'd1 || o_Out !== exp) begin
            errors++; $display("FAIL bp_hold cyc=%0d rdy=%b ack=%b beat=%0d o_Out=%h required 1 0 1 %h", k, Out_rdy, Psum_ack, o_beat, o_Out, exp);
         end
         if (k < 7) tick;
      end
      Psum_rdy = 1'b0;
      Out_ack = 1'b1;
      for (int b = 1; b < NBEAT; b++) begin
         for (int j = 0; j < OUTN; j++) exp[j*W +: W] = 16'(b * 4 + j);
         checks++;
         if (!Out_rdy || o_beat !== 2'(b) || o_Out !== exp) begin
            errors++; $display("FAIL bp_resume beat=%0d o_Out=%h required %0d %h", o_beat, o_Out, b, exp);
         end
         tick;
      end
      Out_ack = 1'b0;
   endtask

   task automatic test_clear_after_drain;
      logic [OUTN*W-1:0] exp;
      exp = {OUTN{16'd7}};
      Out_ack = 1'b1;
      send(1'b0, 1'b1, fill(16'd7));
      for (int b = 0; b < NBEAT; b++) begin
         checks++;
         if (!Out_rdy || o_beat !== 2'(b) || o_Out !== exp) begin
            errors++; $display("FAIL clear_after_drain beat=%0d o_Out=%h required %0d %h", o_beat, o_Out, b, exp);
         end
         tick;
      end
      checks++;
      if (!Psum_ack) begin errors++; $display("FAIL clear_return Psum_ack=%b required 1", Psum_ack); end
      Out_ack = 1'b0;
   endtask

   initial begin
      test_reset;
      test_reset_mid_drain;
      test_three_pass;
      test_saturation;
      test_relu;
      test_backpressure;
      test_clear_after_drain;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
